// File: rtl/uart_inst_loader.sv
// 8N1 UART receiver that packs byte pairs (high byte first) into 16-bit instruction words
// for the fetch stage, with a partial-word timeout and a stop-bit framing error strobe.
module uart_inst_loader #(
   parameter int CLKS_PER_BIT = 434,
   parameter int TIMEOUT_BITS = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_uart_rx,
   output logic [15:0] o_uart_inst,
   output logic        o_uart_inst_en,
   output logic        o_frame_err,
   output logic [15:0] o_word_cnt
);

   localparam int CW   = $clog2(CLKS_PER_BIT);
   localparam int TLIM = TIMEOUT_BITS * CLKS_PER_BIT;
   localparam int TW   = $clog2(TLIM + 1);
   localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [TW-1:0] TO_LAST   = TW'(TLIM);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        state, state_nxt;
   logic          rx_meta, rxs;
   logic [CW-1:0] tick_cnt;
   logic [2:0]    bit_cnt;
   logic [7:0]    shreg;
   logic [7:0]    hi_byte;
   logic          phase_lo;
   logic [TW-1:0] to_cnt;
   logic          tick_done, start_edge, byte_ok, byte_bad, timeout;

   always_ff @(posedge clk) begin
      if (reset) begin
         rx_meta <= 1'b1;
         rxs     <= 1'b1;
      end else begin
         rx_meta <= i_uart_rx;
         rxs     <= rx_meta;
      end
   end

   // START waits half a bit so every later sample lands mid-bit
   always_comb begin
      state_nxt  = state;
      tick_done  = 1'b0;
      start_edge = 1'b0;
      byte_ok    = 1'b0;
      byte_bad   = 1'b0;
      case (state)
         IDLE: begin
            if (!rxs) begin
               start_edge = 1'b1;
               state_nxt  = START;
            end
         end
         START: begin
            if (tick_cnt == HALF_LAST) begin
               tick_done = 1'b1;
               state_nxt = rxs ? IDLE : DATA;
            end
         end
         DATA: begin
            if (tick_cnt == FULL_LAST) begin
               tick_done = 1'b1;
               if (bit_cnt == 3'd7) state_nxt = STOP;
            end
         end
         STOP: begin
            if (tick_cnt == FULL_LAST) begin
               tick_done = 1'b1;
               state_nxt = IDLE;
               byte_ok   = rxs;
               byte_bad  = !rxs;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         tick_cnt <= '0;
         bit_cnt  <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE || tick_done) tick_cnt <= '0;
         else                            tick_cnt <= tick_cnt + 1'b1;
         if (start_edge)                      bit_cnt <= '0;
         else if (state == DATA && tick_done) bit_cnt <= bit_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (state == DATA && tick_done) shreg <= {rxs, shreg[7:1]};
      if (byte_ok && !phase_lo)       hi_byte <= shreg;
   end

   assign timeout = phase_lo && (to_cnt == TO_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         phase_lo       <= 1'b0;
         to_cnt         <= '0;
         o_uart_inst    <= '0;
         o_uart_inst_en <= 1'b0;
         o_frame_err    <= 1'b0;
         o_word_cnt     <= '0;
      end else begin
         o_uart_inst_en <= 1'b0;
         o_frame_err    <= byte_bad;
         if (byte_bad) begin
            phase_lo <= 1'b0;
         end else if (byte_ok) begin
            if (!phase_lo) begin
               phase_lo <= 1'b1;
            end else begin
               o_uart_inst    <= {hi_byte, shreg};
               o_uart_inst_en <= 1'b1;
               o_word_cnt     <= o_word_cnt + 16'd1;
               phase_lo       <= 1'b0;
            end
         end else if (timeout) begin
            phase_lo <= 1'b0;
         end
         // Only idle line time counts toward dropping a stale high byte
         if (start_edge || (byte_ok && !phase_lo))     to_cnt <= '0;
         else if (phase_lo && state == IDLE && !timeout) to_cnt <= to_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_uart_inst_loader.sv
// Directed bench for uart_inst_loader: stimulus pushes expected words into a queue,
// an independent monitor pops and compares on every strobe.
module tb_uart_inst_loader;

   localparam int CPB = 8;
   localparam int TOB = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        rx;
   logic [15:0] inst;
   logic        inst_en;
   logic        frame_err;
   logic [15:0] word_cnt;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_q[$];
   int          ferr_pending = 0;
   logic [15:0] exp_cnt = 16'd0;

   uart_inst_loader #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(TOB)) dut (
      .clk(clk),
      .reset(reset),
      .i_uart_rx(rx),
      .o_uart_inst(inst),
      .o_uart_inst_en(inst_en),
      .o_frame_err(frame_err),
      .o_word_cnt(word_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", name, act, exp);
      end
   endtask

   task automatic expect_word(input logic [15:0] w);
      exp_cnt = exp_cnt + 16'd1;
      exp_q.push_back({w, exp_cnt});
   endtask

   task automatic idle_bits(input int n);
      rx = 1'b1;
      repeat (n * CPB) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_val);
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      rx = stop_val;
      repeat (CPB) @(negedge clk);
      rx = 1'b1;
   endtask

   // Monitor: every strobe is matched against the scoreboard
   always @(negedge clk) begin
      if (!reset) begin
         if (inst_en) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_word got %h expected no strobe", inst);
            end else begin
               logic [31:0] e;
               e = exp_q.pop_front();
               check("word", inst, e[31:16]);
               check("word_cnt", word_cnt, e[15:0]);
            end
         end
         if (frame_err) begin
            checks++;
            if (ferr_pending == 0) begin
               errors++;
               $display("FAIL unexpected_frame_err got 1 expected 0");
            end else begin
               ferr_pending--;
            end
         end
         if (inst_en && frame_err) begin
            checks++;
            errors++;
            $display("FAIL en_and_ferr_coincide got 1 expected 0");
         end
      end
   end

   initial begin
      reset = 1'b1;
      rx    = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_inst", inst, 16'h0000);
      check("reset_cnt", word_cnt, 16'h0000);
      check("reset_en", {15'd0, inst_en}, 16'h0000);
      check("reset_ferr", {15'd0, frame_err}, 16'h0000);
      reset = 1'b0;
      idle_bits(2);

      // 1: basic pair
      send_byte(8'h12, 1'b1);
      expect_word(16'h1234);
      send_byte(8'h34, 1'b1);
      idle_bits(2);

      // 2: back-to-back frames with no idle gap
      send_byte(8'hAB, 1'b1);
      expect_word(16'hABCD);
      send_byte(8'hCD, 1'b1);
      send_byte(8'hEF, 1'b1);
      expect_word(16'hEF01);
      send_byte(8'h01, 1'b1);
      idle_bits(2);

      // 3: short low glitch is ignored
      rx = 1'b0;
      repeat (3) @(negedge clk);
      idle_bits(3);
      send_byte(8'h55, 1'b1);
      expect_word(16'h55AA);
      send_byte(8'hAA, 1'b1);
      idle_bits(2);

      // 4: low byte with bad stop bit yields an error and no word
      send_byte(8'h12, 1'b1);
      ferr_pending++;
      send_byte(8'h34, 1'b0);
      idle_bits(2);
      send_byte(8'h56, 1'b1);
      expect_word(16'h5678);
      send_byte(8'h78, 1'b1);
      idle_bits(2);

      // 5: high byte times out after a long idle
      send_byte(8'h12, 1'b1);
      idle_bits(40);
      send_byte(8'h34, 1'b1);
      expect_word(16'h3456);
      send_byte(8'h56, 1'b1);
      idle_bits(2);

      // 6: reset during data bit 4 of the low byte
      send_byte(8'h12, 1'b1);
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         rx = 1'(8'h34 >> i);
         repeat (CPB) @(negedge clk);
      end
      rx = 1'b1;
      repeat (CPB / 2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("midframe_reset_inst", inst, 16'h0000);
      check("midframe_reset_cnt", word_cnt, 16'h0000);
      check("midframe_reset_en", {15'd0, inst_en}, 16'h0000);
      repeat (2) @(negedge clk);
      reset   = 1'b0;
      exp_cnt = 16'd0;
      idle_bits(2);
      send_byte(8'h9A, 1'b1);
      expect_word(16'h9ABC);
      send_byte(8'hBC, 1'b1);
      idle_bits(4);

      check("words_outstanding", 16'(exp_q.size()), 16'd0);
      check("ferr_outstanding", 16'(ferr_pending), 16'd0);
      check("final_inst", inst, 16'h9ABC);
      check("final_cnt", word_cnt, 16'h0001);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
